alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the register bank.
- Consumes the two 32-bit read-port values (source_1, source_2) plus opcode and destination index.
- Performs single-cycle arithmetic/logic ops, iterative shifts, and an optional iterative multiply.
- Returns result, destination index and a one-cycle write strobe, which feed the LDR mux and the destination decoder for writeback.

Parameters:
DATA_W, 32, datapath width; source_1, source_2 and result width
SHAMT_W, 5, shift-amount width, taken from source_2[SHAMT_W-1:0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  operation request; accepted only when busy=0
opcode  input  4  operation select (see Behaviour)
source_1  input  DATA_W  operand A from register bank read port 1
source_2  input  DATA_W  operand B / shift amount from read port 2
dest_in  input  4  destination register index for writeback
busy  output  1  high from accept edge until done edge inclusive
done  output  1  one-cycle completion pulse
result  output  DATA_W  operation result; valid while done=1, held afterwards
dest_out  output  4  captured dest_in; valid with done
wr_en  output  1  writeback strobe: done AND opcode writes a register
err  output  1  high with done for an illegal opcode
flags  output  4  {N,Z,C,V}; registered, updated only on done

Behaviour:
- Interface: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset values: busy=0, done=0, wr_en=0, err=0, result=0, dest_out=0, flags=0. FSM returns to IDLE.
- Reset asserted mid-operation aborts it. No done or wr_en is issued for the aborted op.
- FSM states: IDLE, SHIFT, MUL, DONE.
- IDLE:
  - start=1 at edge E0 captures opcode, operands and dest_in; busy goes high.
  - Single-cycle ops go to DONE.
  - LSL/LSR/ASR go to SHIFT, or straight to DONE if the amount is 0.
  - MUL goes to MUL.
- SHIFT: one bit per edge; decrements the amount; goes to DONE when it reaches 0. Shift by n → done high after edge E(n+1).
- MUL: shift-add, one multiplier bit per edge, 32 edges, then DONE. done high after edge E33. result = low DATA_W bits of the unsigned product.
- DONE: done=1 for exactly one cycle, then IDLE with busy=0. A new start is accepted on the edge leaving DONE only if busy=0 at that edge, i.e. the next cycle. No back-to-back overlap.
- start while busy=1 is ignored; there is no queue. Operand changes after capture have no effect.
- Opcodes:
  - 0000 ADD
  - 0001 SUB (A−B)
  - 0010 AND
  - 0011 ORR
  - 0100 EOR
  - 0101 MOV (result=B)
  - 0110 LSL
  - 0111 LSR
  - 1000 ASR
  - 1001 CMP: flags as SUB, wr_en=0, result=A−B
  - 1010 MUL
  - 1011–1111 illegal
- Flags:
  - N=result[DATA_W-1]; Z=(result==0).
  - ADD: C=carry out; V=signed overflow.
  - SUB/CMP: C=1 when no borrow (A≥B unsigned); V=signed overflow.
  - Logic/MOV/MUL: C and V unchanged.
  - Shifts: C=last bit shifted out (unchanged if amount 0); V unchanged.
  - Shift amounts ≥ DATA_W are impossible with SHAMT_W=5, and any value 0–31 is legal.
- Illegal opcode: DONE after 1 cycle with err=1, wr_en=0, result=0, flags unchanged.

Optional Feature:
ALU_MUL_EN
- Defined: opcode 1010 runs the 32-cycle MUL state as specified.
- Undefined: MUL state and multiplier logic are absent; opcode 1010 is treated as illegal (err=1, wr_en=0, 1-cycle latency).

Test Plan:
- Reset then ADD: A=0x7FFFFFFF, B=0x00000001, dest_in=3 → one cycle later done=1, wr_en=1, result=0x80000000, dest_out=3, flags N=1 Z=0 C=0 V=1.
- CMP: A=5, B=5 → done after 1 cycle, wr_en=0, result=0, flags Z=1 C=1 N=0 V=0.
- ASR: A=0x80000010, B=4 → done exactly 5 cycles after accept, result=0xF8000001, C=0. Repeat with B=0 → done after 1 cycle, result=A, C unchanged.
- MUL with ALU_MUL_EN: A=0x00010003, B=0x00020005 → done 33 cycles after accept, result=0x000B000F. Without the macro → done after 1 cycle, err=1.
- Assert start with new operands during a 10-cycle LSL → ignored; original result intact; a new op is accepted only after busy falls.
- Drop rst_n during MUL cycle 12 → all outputs 0 immediately; no done pulse; next start behaves normally.

Source files
------------

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage between the register bank and writeback.
// Single-cycle ALU ops, bit-serial shifts and, when ALU_MUL_EN is defined,
// a 32-step shift-add multiplier. Without ALU_MUL_EN opcode 1010 is illegal.
module alu_exec_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] source_1,
  input  logic [DATA_W-1:0] source_2,
  input  logic [3:0]        dest_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        dest_out,
  output logic              wr_en,
  output logic              err,
  output logic [3:0]        flags
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_ORR = 4'd3, OP_EOR = 4'd4, OP_MOV = 4'd5,
                         OP_LSL = 4'd6, OP_LSR = 4'd7, OP_ASR = 4'd8,
                         OP_CMP = 4'd9, OP_MUL = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef ALU_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;      // operand A; shift value / multiplicand
  logic [DATA_W-1:0]   b_q, b_d;      // operand B; multiplier
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;  // remaining shift / multiply steps
  logic                c_q, c_d;      // last bit shifted out
  logic [3:0]          dest_q, dest_d;
  logic                done_q, done_d;
  logic                wr_en_q, wr_en_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          dest_out_q, dest_out_d;
  logic [3:0]          flags_q, flags_d;
`ifdef ALU_MUL_EN
  logic [DATA_W-1:0]   acc_q, acc_d;  // partial product
`endif

  logic [DATA_W:0]     add_ext, sub_ext;
  logic [DATA_W-1:0]   res;
  logic [3:0]          nf;
  logic                legal, wr;
  logic                is_shift;

  assign add_ext  = {1'b0, a_q} + {1'b0, b_q};
  assign sub_ext  = {1'b0, a_q} + {1'b0, ~b_q} + (DATA_W+1)'(1);
  assign is_shift = (opcode == OP_LSL) || (opcode == OP_LSR) || (opcode == OP_ASR);

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign wr_en    = wr_en_q;
  assign err      = err_q;
  assign result   = result_q;
  assign dest_out = dest_out_q;
  assign flags    = flags_q;

  // Next-state, datapath stepping and completion outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    dest_d     = dest_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    err_d      = 1'b0;
    result_d   = result_q;
    dest_out_d = dest_out_q;
    flags_d    = flags_q;
`ifdef ALU_MUL_EN
    acc_d      = acc_q;
`endif
    res        = '0;
    nf         = flags_q;
    legal      = 1'b1;
    wr         = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = opcode;
          a_d     = source_1;
          b_d     = source_2;
          dest_d  = dest_in;
          cnt_d   = source_2[SHAMT_W-1:0];
          c_d     = flags_q[1];           // zero-length shift keeps C
          state_d = S_DONE;
          if (is_shift && (source_2[SHAMT_W-1:0] != '0)) state_d = S_SHIFT;
`ifdef ALU_MUL_EN
          if (opcode == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = SHAMT_W'(DATA_W-1);
            acc_d   = '0;
          end
`endif
        end
      end
      S_SHIFT: begin
        case (op_q)
          OP_LSL:  begin c_d = a_q[DATA_W-1]; a_d = a_q << 1; end
          OP_LSR:  begin c_d = a_q[0];        a_d = a_q >> 1; end
          default: begin c_d = a_q[0];        a_d = {a_q[DATA_W-1], a_q[DATA_W-1:1]}; end
        endcase
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        case (op_q)
          OP_ADD: begin
            res   = add_ext[DATA_W-1:0];
            nf[1] = add_ext[DATA_W];
            nf[0] = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (res[DATA_W-1] != a_q[DATA_W-1]);
          end
          OP_SUB, OP_CMP: begin
            res   = sub_ext[DATA_W-1:0];
            nf[1] = sub_ext[DATA_W];
            nf[0] = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (res[DATA_W-1] != a_q[DATA_W-1]);
            wr    = (op_q != OP_CMP);
          end
          OP_AND: res = a_q & b_q;
          OP_ORR: res = a_q | b_q;
          OP_EOR: res = a_q ^ b_q;
          OP_MOV: res = b_q;
          OP_LSL, OP_LSR, OP_ASR: begin
            res   = a_q;
            nf[1] = c_q;
          end
`ifdef ALU_MUL_EN
          OP_MUL: res = acc_q;
`endif
          default: legal = 1'b0;
        endcase
        nf[3]      = res[DATA_W-1];
        nf[2]      = (res == '0);
        done_d     = 1'b1;
        dest_out_d = dest_q;
        state_d    = S_IDLE;
        if (legal) begin
          result_d = res;
          flags_d  = nf;
          wr_en_d  = wr;
        end else begin
          result_d = '0;
          err_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      dest_q     <= '0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      dest_out_q <= '0;
      flags_q    <= '0;
`ifdef ALU_MUL_EN
      acc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      dest_q     <= dest_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      err_q      <= err_d;
      result_q   <= result_d;
      dest_out_q <= dest_out_d;
      flags_q    <= flags_d;
`ifdef ALU_MUL_EN
      acc_q      <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized + directed bench for alu_exec_stage against an arithmetic model.
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [31:0] source_1 = '0, source_2 = '0;
  logic [3:0]  dest_in = '0;
  logic        busy, done, wr_en, err;
  logic [31:0] result;
  logic [3:0]  dest_out, flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags = '0;  // model of the flag register

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .source_1(source_1), .source_2(source_2), .dest_in(dest_in),
    .busy(busy), .done(done), .result(result), .dest_out(dest_out),
    .wr_en(wr_en), .err(err), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected outcome from the opcode table, using plain arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f, output logic e,
                       output logic w, output int lat);
    longint sa, sb, s;
    int n;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    c  = mflags[1];
    v  = mflags[0];
    e  = 1'b0;
    w  = 1'b1;
    lat = 1;
    r  = '0;
    case (op)
      4'd0: begin r = a + b; c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                  s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1, 4'd9: begin r = a - b; c = (a >= b);
                  s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                  w = (op == 4'd1); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = b;
      4'd6: begin r = a << n; if (n != 0) c = a[32-n]; lat = (n == 0) ? 1 : n + 1; end
      4'd7: begin r = a >> n; if (n != 0) c = a[n-1];  lat = (n == 0) ? 1 : n + 1; end
      4'd8: begin r = $signed(a) >>> n; if (n != 0) c = a[n-1]; lat = (n == 0) ? 1 : n + 1; end
      4'd10: if (MUL_EN) begin r = a * b; lat = 33; end else e = 1'b1;
      default: e = 1'b1;
    endcase
    if (e) begin
      r = '0; w = 1'b0; f = mflags;
    end else begin
      f = {r[31], r == 32'd0, c, v};
    end
  endtask

  // Issue one op from a cycle where busy=0 and return in its done cycle.
  // spam re-asserts start with junk operands while the op is in flight.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] d, input bit spam);
    logic [31:0] er; logic [3:0] ef; logic ee, ew; int elat, lat;
    model(op, a, b, er, ef, ee, ew, elat);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    opcode = op; source_1 = a; source_2 = b; dest_in = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; opcode = 4'($urandom); source_1 = $urandom; source_2 = $urandom;
    dest_in = 4'($urandom);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("wr_pulse", {31'd0, wr_en}, 32'd0);
    chk("busy_acc", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      chk("busy_run", {31'd0, busy}, 32'd1);
      if (spam && i < 5) begin
        start = 1'b1; opcode = 4'd0; source_1 = $urandom; source_2 = $urandom;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk($sformatf("lat_op%0d", op), lat, elat);
    if (lat != 0) begin
      chk($sformatf("res_op%0d", op), result, er);
      chk($sformatf("flg_op%0d", op), {28'd0, flags}, {28'd0, ef});
      chk("wr_en", {31'd0, wr_en}, {31'd0, ew});
      chk("err", {31'd0, err}, {31'd0, ee});
      chk("dest_out", {28'd0, dest_out}, {28'd0, d});
      chk("busy_done", {31'd0, busy}, 32'd0);
      mflags = ef;
    end
  endtask

  initial begin
    int seen;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_dest", {28'd0, dest_out}, 32'd0);
    chk("rst_wr_err", {30'd0, wr_en, err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan.
    do_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 1'b0);
    chk("add_flags", {28'd0, flags}, 32'h0000_0009);
    do_op(4'd9, 32'd5, 32'd5, 4'd1, 1'b0);
    chk("cmp_flags", {28'd0, flags}, 32'h0000_0006);
    do_op(4'd8, 32'h8000_0010, 32'd4, 4'd2, 1'b0);
    chk("asr_res", result, 32'hF800_0001);
    do_op(4'd8, 32'h8000_0010, 32'd0, 4'd2, 1'b0);
    do_op(4'd10, 32'h0001_0003, 32'h0002_0005, 4'd7, 1'b0);
    if (MUL_EN) chk("mul_res", result, 32'h000B_000F);
    else        chk("mul_err", {31'd0, err}, 32'd1);
    do_op(4'd6, 32'h1234_5678, 32'd10, 4'd9, 1'b1);
    do_op(4'd15, 32'h1, 32'h2, 4'd4, 1'b0);
    do_op(4'd7, 32'h8000_0001, 32'd31, 4'd5, 1'b0);
    do_op(4'd6, 32'h8000_0001, 32'd1, 4'd5, 1'b0);

    // Reset in the middle of a long operation.
    opcode = MUL_EN ? 4'd10 : 4'd6; source_1 = 32'hDEAD_BEEF; source_2 = 32'h0000_001E;
    dest_in = 4'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_res", result, 32'd0);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    chk("abort_dest", {28'd0, dest_out}, 32'd0);
    chk("abort_pulses", {29'd0, done, wr_en, err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    mflags = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || wr_en) seen++;
    end
    chk("abort_nodone", seen, 32'd0);
    do_op(4'd1, 32'd3, 32'd7, 4'd8, 1'b0);

    // Random ops, back to back from each done cycle.
    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      do_op(op, $urandom, $urandom, 4'($urandom), ($urandom_range(0, 3) == 0));
    end
    @(posedge clk); #1;
    chk("final_done_low", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
